// File: rtl/issue_rat_prf_redeemer.sv
// Release queue feeding the rename freelist: holds freed PRFs until their flush group
// commits, drops them when it is abandoned. Optional `ISSUE_RAT_REDEEMER_DUP_CHECK_EN adds o_dup_error.
module issue_rat_prf_redeemer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PRF_WIDTH  = 6,
    parameter int FGR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [PRF_WIDTH-1:0]  i_release_prf,
    input  logic [FGR_WIDTH-1:0]  i_release_fgr,
    input  logic                  i_release_fgr_speculative,
    input  logic                  i_release_valid,
    output logic                  o_release_ready,
    output logic [PRF_WIDTH-1:0]  o_redeemed_prf,
    output logic                  o_redeemed_valid,
    input  logic                  i_redeemed_ready,
    input  logic [FGR_WIDTH-1:0]  i_commit_fgr,
    input  logic                  i_commit_valid,
    input  logic [FGR_WIDTH-1:0]  i_abandon_fgr,
    input  logic                  i_abandon_valid,
    output logic [DEPTH_LOG2:0]   o_count
`ifdef ISSUE_RAT_REDEEMER_DUP_CHECK_EN
    ,
    output logic                  o_dup_error
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0]   ptr_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    ptr_t wptr, rptr, count;
    idx_t widx, ridx;

    logic [PRF_WIDTH-1:0] prf_mem [DEPTH];
    logic [FGR_WIDTH-1:0] fgr_mem [DEPTH];
    logic [DEPTH-1:0]     spec_q, killed_q;
    logic [DEPTH-1:0]     slot_valid, commit_hit, abandon_hit;

    logic full, empty, push, pop;
    logic push_commit_hit, push_abandon_hit;

    assign widx  = wptr[DEPTH_LOG2-1:0];
    assign ridx  = rptr[DEPTH_LOG2-1:0];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) && (widx == ridx);

    assign push = i_release_valid && !full;

    // A killed head drains silently; a live speculative head blocks everything behind it.
    assign o_redeemed_valid = !empty && !killed_q[ridx] && !spec_q[ridx];
    assign pop = !empty && (killed_q[ridx] || (!spec_q[ridx] && i_redeemed_ready));

    assign o_redeemed_prf  = o_redeemed_valid ? prf_mem[ridx] : '0;
    assign o_release_ready = !full;
    assign o_count         = count;

    assign push_abandon_hit = i_abandon_valid && (i_release_fgr == i_abandon_fgr);
    assign push_commit_hit  = i_commit_valid && (i_release_fgr == i_commit_fgr);

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        slot_valid  = '0;
        commit_hit  = '0;
        abandon_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i]  = {1'b0, idx_t'(idx_t'(i) - ridx)} < count;
            abandon_hit[i] = slot_valid[i] && spec_q[i] && i_abandon_valid &&
                             (fgr_mem[i] == i_abandon_fgr);
            commit_hit[i]  = slot_valid[i] && spec_q[i] && i_commit_valid &&
                             (fgr_mem[i] == i_commit_fgr);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Abandon takes priority over a same-group commit in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spec_q   <= '0;
            killed_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (idx_t'(i) == widx)) begin
                    spec_q[i]   <= i_release_fgr_speculative && !(push_commit_hit && !push_abandon_hit);
                    killed_q[i] <= i_release_fgr_speculative && push_abandon_hit;
                end else if (abandon_hit[i]) begin
                    killed_q[i] <= 1'b1;
                end else if (commit_hit[i]) begin
                    spec_q[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload storage is not reset; the reset flags and pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            prf_mem[widx] <= i_release_prf;
            fgr_mem[widx] <= i_release_fgr;
        end
    end

`ifdef ISSUE_RAT_REDEEMER_DUP_CHECK_EN
    logic dup_hit;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && !killed_q[i] && (prf_mem[i] == i_release_prf)) dup_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)             o_dup_error <= 1'b0;
        else if (push && dup_hit) o_dup_error <= 1'b1;
    end
`endif

endmodule
